// File: rtl/sram9t_rw_ctrl.sv
// Row controller for the 9T SRAM array of the low-power CAM.
// Accepts single-row read/write requests over valid/ready, sequences the
// write wordline and data lines for writes, and the precharge / read
// wordline / sample sequence for reads. Every output is registered except
// req_ready_o, which decodes the IDLE state.
module sram9t_rw_ctrl #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int AW      = 4,
    parameter int PRE_CYC = 2,
    parameter int WR_CYC  = 2,
    parameter int RD_CYC  = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    // request channel
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [COLS-1:0] req_wdata_i,
    // response channel
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [COLS-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    // array side
    output logic [ROWS-1:0] wlwr_o,
    output logic [COLS-1:0] dl_o,
    output logic [COLS-1:0] dlb_o,
    output logic [ROWS-1:0] rwl_o,
    output logic            preb_o,
    input  logic [COLS-1:0] rbl_i
);

    // One counter times every multi-cycle state; it holds (cycles - 1).
    localparam int MAX_CYC = (PRE_CYC > WR_CYC) ?
                             ((PRE_CYC > RD_CYC) ? PRE_CYC : RD_CYC) :
                             ((WR_CYC > RD_CYC) ? WR_CYC : RD_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] WR_LOAD  = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_CYC - 1);
    localparam logic [AW:0]   ROWS_W   = (AW + 1)'(ROWS);
    localparam logic [ROWS-1:0] ROW0   = {{(ROWS - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_PRECH,
        S_GAP,
        S_EVAL,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   ctr_q, ctr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [COLS-1:0] wdata_q, wdata_d;

    logic [ROWS-1:0] wlwr_q, wlwr_d;
    logic [ROWS-1:0] rwl_q, rwl_d;
    logic [COLS-1:0] dl_q, dl_d;
    logic [COLS-1:0] dlb_q, dlb_d;
    logic            preb_q, preb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [ROWS-1:0] row_sel;

    assign req_ready_o = (state_q == S_IDLE);

    // Next-state, counter and captured-request logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; an unassigned path in always_comb would infer a latch.
        state_d     = state_q;
        ctr_d       = ctr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    rsp_rdata_d = '0;
                    if ({1'b0, req_addr_i} >= ROWS_W) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (req_we_i) begin
                        ctr_d   = WR_LOAD;
                        state_d = S_WRITE;
                    end else begin
                        ctr_d   = PRE_LOAD;
                        state_d = S_PRECH;
                    end
                end
            end
            S_WRITE: begin
                if (ctr_q == '0) state_d = S_RESP;
                else             ctr_d   = ctr_q - 1'b1;
            end
            S_PRECH: begin
                if (ctr_q == '0) state_d = S_GAP;
                else             ctr_d   = ctr_q - 1'b1;
            end
            S_GAP: begin
                // Break-before-make: precharge is released a full cycle
                // before the read wordline fires.
                ctr_d   = RD_LOAD;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (ctr_q == '0) begin
                    rsp_rdata_d = rbl_i;
                    state_d     = S_RESP;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered array and response outputs, decoded from the next state so
    // they change on the same edge as the state they belong to.
    always_comb begin
        row_sel     = ROW0 << addr_d;
        wlwr_d      = (state_d == S_WRITE) ? row_sel : '0;
        dl_d        = (state_d == S_WRITE) ? wdata_d : '0;
        dlb_d       = (state_d == S_WRITE) ? ~wdata_d : '0;
        rwl_d       = (state_d == S_EVAL)  ? row_sel : '0;
        preb_d      = (state_d != S_PRECH);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State, counter and captured request registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn_i) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Output registers; reset drops wordlines and data lines asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wlwr_q      <= '0;
            rwl_q       <= '0;
            dl_q        <= '0;
            dlb_q       <= '0;
            preb_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            wlwr_q      <= wlwr_d;
            rwl_q       <= rwl_d;
            dl_q        <= dl_d;
            dlb_q       <= dlb_d;
            preb_q      <= preb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign wlwr_o      = wlwr_q;
    assign rwl_o       = rwl_q;
    assign dl_o        = dl_q;
    assign dlb_o       = dlb_q;
    assign preb_o      = preb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
